// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection and bubble counter
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Reg_Dst,
  input  logic              Branch,
  input  logic              BranchN,
  input  logic              Jump,
  input  logic              Mem_Read,
  input  logic              Mem_Write,
  input  logic              Mem_To_Reg,
  input  logic              ALU_Src,
  input  logic              Reg_Write,
  input  logic [2:0]        ALU_Op,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [5:0]        id_func,
  input  logic              Flush,
  input  logic              Stall_In,
  output logic              NoOp,
  output logic              PC_Write,
  output logic              IFID_Write,
  output logic              ex_Reg_Dst,
  output logic              ex_Branch,
  output logic              ex_BranchN,
  output logic              ex_Jump,
  output logic              ex_Mem_Read,
  output logic              ex_Mem_Write,
  output logic              ex_Mem_To_Reg,
  output logic              ex_ALU_Src,
  output logic              ex_Reg_Write,
  output logic [2:0]        ex_ALU_Op,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [5:0]        ex_func,
  output logic              ex_valid,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Load in EX whose destination is read by ID; a flush kills ID so no bubble is needed.
  logic rt_nonzero;
  logic rt_match;

  // Hazard detection and front-end enables, purely combinational.
  always_comb begin
    rt_nonzero = (ex_rt != '0);
    rt_match   = (ex_rt == id_rs) || (ex_rt == id_rt);
    NoOp       = ex_valid & ex_Mem_Read & rt_nonzero & rt_match & ~Flush;
    PC_Write   = ~NoOp & ~Stall_In;
    IFID_Write = ~NoOp & ~Stall_In;
  end

  // Control word and valid: cleared on flush or bubble, held on stall, loaded otherwise.
  always_ff @(posedge clk) begin
    if (!rst || Flush || (!Stall_In && NoOp)) begin
      ex_Reg_Dst    <= 1'b0;
      ex_Branch     <= 1'b0;
      ex_BranchN    <= 1'b0;
      ex_Jump       <= 1'b0;
      ex_Mem_Read   <= 1'b0;
      ex_Mem_Write  <= 1'b0;
      ex_Mem_To_Reg <= 1'b0;
      ex_ALU_Src    <= 1'b0;
      ex_Reg_Write  <= 1'b0;
      ex_ALU_Op     <= 3'd0;
      ex_valid      <= 1'b0;
    end else if (!Stall_In) begin
      ex_Reg_Dst    <= Reg_Dst;
      ex_Branch     <= Branch;
      ex_BranchN    <= BranchN;
      ex_Jump       <= Jump;
      ex_Mem_Read   <= Mem_Read;
      ex_Mem_Write  <= Mem_Write;
      ex_Mem_To_Reg <= Mem_To_Reg;
      ex_ALU_Src    <= ALU_Src;
      ex_Reg_Write  <= Reg_Write;
      ex_ALU_Op     <= ALU_Op;
      ex_valid      <= 1'b1;
    end
  end

  // Data fields: loaded on every non-stalled edge (flush overrides stall), contents of bubbles are don't-care.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_pc4  <= '0;
      ex_rd1  <= '0;
      ex_rd2  <= '0;
      ex_imm  <= '0;
      ex_rs   <= '0;
      ex_rt   <= '0;
      ex_rd   <= '0;
      ex_func <= '0;
    end else if (Flush || !Stall_In) begin
      ex_pc4  <= id_pc4;
      ex_rd1  <= id_rd1;
      ex_rd2  <= id_rd2;
      ex_imm  <= id_imm;
      ex_rs   <= id_rs;
      ex_rt   <= id_rt;
      ex_rd   <= id_rd;
      ex_func <= id_func;
    end
  end

  // Saturating count of load-use bubbles actually inserted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bubble_cnt <= '0;
    end else if (NoOp && !Stall_In && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        Reg_Dst, Branch, BranchN, Jump, Mem_Read, Mem_Write, Mem_To_Reg, ALU_Src, Reg_Write;
  logic [2:0]  ALU_Op;
  logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_func;
  logic        Flush, Stall_In;
  logic        NoOp, PC_Write, IFID_Write;
  logic        ex_Reg_Dst, ex_Branch, ex_BranchN, ex_Jump, ex_Mem_Read, ex_Mem_Write;
  logic        ex_Mem_To_Reg, ex_ALU_Src, ex_Reg_Write;
  logic [2:0]  ex_ALU_Op;
  logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [5:0]  ex_func;
  logic        ex_valid;
  logic [1:0]  bubble_cnt;

  int checks = 0;
  int failures = 0;

  id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .Reg_Dst(Reg_Dst), .Branch(Branch), .BranchN(BranchN), .Jump(Jump),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_To_Reg(Mem_To_Reg),
    .ALU_Src(ALU_Src), .Reg_Write(Reg_Write), .ALU_Op(ALU_Op),
    .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_func(id_func),
    .Flush(Flush), .Stall_In(Stall_In),
    .NoOp(NoOp), .PC_Write(PC_Write), .IFID_Write(IFID_Write),
    .ex_Reg_Dst(ex_Reg_Dst), .ex_Branch(ex_Branch), .ex_BranchN(ex_BranchN), .ex_Jump(ex_Jump),
    .ex_Mem_Read(ex_Mem_Read), .ex_Mem_Write(ex_Mem_Write), .ex_Mem_To_Reg(ex_Mem_To_Reg),
    .ex_ALU_Src(ex_ALU_Src), .ex_Reg_Write(ex_Reg_Write), .ex_ALU_Op(ex_ALU_Op),
    .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_func(ex_func),
    .ex_valid(ex_valid), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_lw(input logic [4:0] rt, input logic [31:0] pc);
    {Reg_Dst, Branch, BranchN, Jump} = 4'b0000;
    {Mem_Read, Mem_Write, Mem_To_Reg, ALU_Src, Reg_Write} = 5'b10111;
    ALU_Op = 3'd0;
    id_pc4 = pc; id_rd1 = 32'h1000; id_rd2 = 32'h0; id_imm = 32'h4;
    id_rs = 5'd29; id_rt = rt; id_rd = 5'd0; id_func = 6'd0;
    #1;
  endtask

  task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] pc);
    {Reg_Dst, Branch, BranchN, Jump} = 4'b1000;
    {Mem_Read, Mem_Write, Mem_To_Reg, ALU_Src, Reg_Write} = 5'b00001;
    ALU_Op = 3'd2;
    id_pc4 = pc; id_rd1 = 32'h11; id_rd2 = 32'h22; id_imm = 32'h5020;
    id_rs = rs; id_rt = rt; id_rd = rd; id_func = 6'h20;
    #1;
  endtask

  initial begin
    // reset with arbitrary inputs
    rst = 1'b0; Flush = 1'b0; Stall_In = 1'b0;
    {Reg_Dst, Branch, BranchN, Jump, Mem_Read, Mem_Write, Mem_To_Reg, ALU_Src, Reg_Write} = 9'h1FF;
    ALU_Op = 3'd7; id_pc4 = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    id_rs = 5'd8; id_rt = 5'd8; id_rd = 5'd8; id_func = 6'h3F;
    step();
    step();
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_cnt", {30'd0, bubble_cnt}, 32'd0);
    check("rst_ctrl", {23'd0, ex_Reg_Dst, ex_Branch, ex_BranchN, ex_Jump, ex_Mem_Read,
                       ex_Mem_Write, ex_Mem_To_Reg, ex_ALU_Src, ex_Reg_Write}, 32'd0);
    check("rst_aluop", {29'd0, ex_ALU_Op}, 32'd0);
    check("rst_pc4", ex_pc4, 32'd0);
    check("rst_rt", {27'd0, ex_rt}, 32'd0);
    check("rst_noop", {31'd0, NoOp}, 32'd0);

    // lw rt=8 then add rs=8: one bubble
    rst = 1'b1;
    drive_lw(5'd8, 32'h104);
    check("lw_noop_pre", {31'd0, NoOp}, 32'd0);
    step();
    check("lw_valid", {31'd0, ex_valid}, 32'd1);
    check("lw_memrd", {31'd0, ex_Mem_Read}, 32'd1);
    check("lw_rt", {27'd0, ex_rt}, 32'd8);
    drive_add(5'd8, 5'd9, 5'd10, 32'h108);
    check("lu_noop", {31'd0, NoOp}, 32'd1);
    check("lu_pcw", {31'd0, PC_Write}, 32'd0);
    check("lu_ifidw", {31'd0, IFID_Write}, 32'd0);
    step();
    check("bub_valid", {31'd0, ex_valid}, 32'd0);
    check("bub_ctrl", {20'd0, ex_ALU_Op, ex_Reg_Dst, ex_Branch, ex_BranchN, ex_Jump, ex_Mem_Read,
                       ex_Mem_Write, ex_Mem_To_Reg, ex_ALU_Src, ex_Reg_Write}, 32'd0);
    check("bub_cnt", {30'd0, bubble_cnt}, 32'd1);
    check("bub_noop", {31'd0, NoOp}, 32'd0);
    check("bub_pcw", {31'd0, PC_Write}, 32'd1);
    step();
    check("add_valid", {31'd0, ex_valid}, 32'd1);
    check("add_regw", {31'd0, ex_Reg_Write}, 32'd1);
    check("add_aluop", {29'd0, ex_ALU_Op}, 32'd2);
    check("add_rd", {27'd0, ex_rd}, 32'd10);
    check("add_pc4", ex_pc4, 32'h108);
    check("add_cnt", {30'd0, bubble_cnt}, 32'd1);

    // lw to r0 never stalls
    drive_lw(5'd0, 32'h10C);
    step();
    drive_add(5'd0, 5'd0, 5'd3, 32'h110);
    check("r0_noop", {31'd0, NoOp}, 32'd0);
    step();
    check("r0_valid", {31'd0, ex_valid}, 32'd1);
    check("r0_cnt", {30'd0, bubble_cnt}, 32'd1);

    // flush during load-use
    drive_lw(5'd8, 32'h114);
    step();
    drive_add(5'd8, 5'd1, 5'd2, 32'h118);
    Flush = 1'b1; #1;
    check("fl_noop", {31'd0, NoOp}, 32'd0);
    check("fl_pcw", {31'd0, PC_Write}, 32'd1);
    step();
    check("fl_valid", {31'd0, ex_valid}, 32'd0);
    check("fl_regw", {31'd0, ex_Reg_Write}, 32'd0);
    check("fl_cnt", {30'd0, bubble_cnt}, 32'd1);
    Flush = 1'b0;

    // external stall during load-use (dependency through rt)
    drive_lw(5'd8, 32'h200);
    step();
    drive_add(5'd3, 5'd8, 5'd4, 32'h204);
    Stall_In = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      check("st_noop", {31'd0, NoOp}, 32'd1);
      check("st_pcw", {31'd0, PC_Write}, 32'd0);
      step();
      check("st_pc4", ex_pc4, 32'h200);
      check("st_memrd", {31'd0, ex_Mem_Read & ex_valid}, 32'd1);
      check("st_cnt", {30'd0, bubble_cnt}, 32'd1);
    end
    Stall_In = 1'b0; #1;
    check("rel_noop", {31'd0, NoOp}, 32'd1);
    check("rel_ifidw", {31'd0, IFID_Write}, 32'd0);
    step();
    check("rel_valid", {31'd0, ex_valid}, 32'd0);
    check("rel_cnt", {30'd0, bubble_cnt}, 32'd2);
    step();
    check("rel_issue", {31'd0, ex_valid & ex_Reg_Write}, 32'd1);
    check("rel_rt", {27'd0, ex_rt}, 32'd8);

    // saturation of the 2-bit counter
    drive_lw(5'd8, 32'h300);
    step();
    drive_add(5'd8, 5'd0, 5'd5, 32'h304);
    step();
    check("sat_cnt3", {30'd0, bubble_cnt}, 32'd3);
    step();
    drive_lw(5'd8, 32'h308);
    step();
    drive_add(5'd8, 5'd0, 5'd5, 32'h30C);
    check("sat_noop", {31'd0, NoOp}, 32'd1);
    step();
    check("sat_hold", {30'd0, bubble_cnt}, 32'd3);
    check("sat_valid", {31'd0, ex_valid}, 32'd0);

    // reset in the middle of a stalled load-use
    drive_lw(5'd8, 32'h400);
    step();
    drive_add(5'd8, 5'd1, 5'd6, 32'h404);
    Stall_In = 1'b1; #1;
    check("rs_noop_pre", {31'd0, NoOp}, 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1; Stall_In = 1'b0; #1;
    check("rs_noop", {31'd0, NoOp}, 32'd0);
    check("rs_pcw", {31'd0, PC_Write}, 32'd1);
    check("rs_cnt", {30'd0, bubble_cnt}, 32'd0);
    step();
    check("rs_issue", {31'd0, ex_valid}, 32'd1);
    check("rs_pc4", ex_pc4, 32'h404);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
